// File: rtl/ram_bus_wbuf.sv
// Single-port byte-enabled RAM slave with an in-order write buffer; rd_data valid 1 cycle after rd_gnt.
// Grants drop while the buffer is full; `define RAM_WB_FORWARD_EN forwards buffered bytes instead of stalling reads that hit.
module ram_bus_wbuf #(
  parameter int WORDS    = 1024,
  parameter int WB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_gnt,
  output logic [31:0] rd_data,
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data,
  output logic        wr_gnt
);
  localparam int IW = $clog2(WORDS);
  localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CW = $clog2(WB_DEPTH + 1);

  logic [31:0]   mem    [WORDS];
  logic [IW-1:0] wb_idx [WB_DEPTH];
  logic [31:0]   wb_dat [WB_DEPTH];
  logic [3:0]    wb_be  [WB_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic [IW-1:0] rd_idx, wr_idx;
  logic          full, empty, push, drain, do_read;
  logic [31:0]   arr_q;
  logic          unused_addr;
`ifdef RAM_WB_FORWARD_EN
  logic [3:0]    fwd_mask, fwd_mask_q;
  logic [31:0]   fwd_dat, fwd_dat_q;
`else
  logic          hit;
`endif

  function automatic logic [PW-1:0] slot(input logic [PW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % WB_DEPTH;
    return PW'(s);
  endfunction

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_idx      = rd_addr[IW+1:2];
  assign wr_idx      = wr_addr[IW+1:2];
  assign unused_addr = ^{rd_addr[31:IW+2], rd_addr[1:0], wr_addr[31:IW+2], wr_addr[1:0]};

  // Scan live entries oldest to newest so later writes win each byte lane.
  always_comb begin
`ifdef RAM_WB_FORWARD_EN
    fwd_mask = '0;
    fwd_dat  = '0;
`else
    hit = 1'b0;
`endif
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (k < int'(count) && wb_idx[slot(head, k)] == rd_idx) begin
`ifdef RAM_WB_FORWARD_EN
        for (int b = 0; b < 4; b++) begin
          if (wb_be[slot(head, k)][b]) begin
            fwd_mask[b]       = 1'b1;
            fwd_dat[8*b +: 8] = wb_dat[slot(head, k)][8*b +: 8];
          end
        end
`else
        hit = 1'b1;
`endif
      end
    end
  end

  assign full   = (count == CW'(WB_DEPTH));
  assign empty  = (count == '0);
  assign wr_gnt = wr_req & ~full & ~rst;
`ifdef RAM_WB_FORWARD_EN
  assign rd_gnt = rd_req & ~full & ~rst;
`else
  assign rd_gnt = rd_req & ~full & ~hit & ~rst;
`endif
  assign do_read = rd_gnt;
  assign push    = wr_gnt & (|wr_be);
  // The array port goes to the drain whenever the buffer is full or no read claims it.
  assign drain   = ~rst & (full | (~do_read & ~empty));

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= nxt(tail);
      if (drain)
        head <= nxt(head);
      if (push && !drain)
        count <= count + 1'b1;
      else if (drain && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_idx[tail] <= wr_idx;
      wb_dat[tail] <= wr_data;
      wb_be[tail]  <= wr_be;
    end
  end

  always_ff @(posedge clk) begin
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_be[head][b])
          mem[wb_idx[head]][8*b +: 8] <= wb_dat[head][8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arr_q <= '0;
`ifdef RAM_WB_FORWARD_EN
      fwd_mask_q <= '0;
      fwd_dat_q  <= '0;
`endif
    end else if (do_read) begin
      arr_q <= mem[rd_idx];
`ifdef RAM_WB_FORWARD_EN
      fwd_mask_q <= fwd_mask;
      fwd_dat_q  <= fwd_dat;
`endif
    end
  end

`ifdef RAM_WB_FORWARD_EN
  always_comb begin
    rd_data = arr_q;
    for (int b = 0; b < 4; b++) begin
      if (fwd_mask_q[b])
        rd_data[8*b +: 8] = fwd_dat_q[8*b +: 8];
    end
  end
`else
  assign rd_data = arr_q;
`endif

endmodule
